// File: rtl/judge_scheduler.sv
// Rhythm-game judgment scheduler: four one-entry lane slots drained by a round-robin
// arbiter into a single grade stream with combo, max-combo and overflow tracking.
module judge_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_active,
    input  logic [3:0] hit_valid,
    input  logic [7:0] hit_grade,
    output logic [1:0] inp,
    output logic [7:0] combo,
    output logic [7:0] max_combo,
    output logic [3:0] pending,
    output logic       overflow,
    output logic       song_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      last;
    logic [3:0][1:0] slot_grade;
    logic            grant_any;
    logic [1:0]      grant_lane;
    logic [1:0]      cand;
    logic [3:0]      grant_onehot;
    logic [1:0]      grant_grade;
    logic [7:0]      combo_next;
    logic            song_end;
    logic            song_start;

    // Search starts just after the last granted lane, so the last winner ranks lowest.
    always_comb begin
        grant_any  = 1'b0;
        grant_lane = last;
        cand       = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + k[1:0];
            if (!grant_any && pending[cand]) begin
                grant_any  = 1'b1;
                grant_lane = cand;
            end
        end
        grant_onehot = grant_any ? (4'b0001 << grant_lane) : 4'b0000;
        grant_grade  = slot_grade[grant_lane];
    end

    always_comb begin
        state_next = state;
        song_end   = 1'b0;
        case (state)
            IDLE:  if (game_active) state_next = RUN;
            RUN:   if (!game_active) state_next = DRAIN;
            DRAIN: begin
                if (pending == 4'b0000 && !grant_any) begin
                    state_next = IDLE;
                    song_end   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        song_start = (state == IDLE) && game_active;
        combo_next = combo;
        if (grant_any) begin
            if (grant_grade == 2'b00)
                combo_next = 8'd0;
            else if (combo != 8'hFF)
                combo_next = combo + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A slot granted this cycle is free to take a new hit at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 4'b0000;
            slot_grade <= '0;
            last       <= 2'd3;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant_onehot[i])
                    pending[i] <= 1'b0;
                if (state == RUN && hit_valid[i] && (!pending[i] || grant_onehot[i])) begin
                    pending[i]    <= 1'b1;
                    slot_grade[i] <= hit_grade[2*i +: 2];
                end
            end
            if (grant_any)
                last <= grant_lane;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inp       <= 2'b00;
            combo     <= 8'd0;
            max_combo <= 8'd0;
            overflow  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            inp       <= grant_any ? grant_grade : 2'b00;
            song_done <= song_end;
            if (song_start) begin
                combo     <= 8'd0;
                max_combo <= 8'd0;
                overflow  <= 1'b0;
            end else begin
                combo     <= combo_next;
                max_combo <= (combo_next > max_combo) ? combo_next : max_combo;
                if (state == RUN && |(hit_valid & pending & ~grant_onehot))
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/judge_scheduler.md
JUDGE_SCHEDULER -- requirements
Module: judge_scheduler

Interface
REQ-001 clk  in  1  single system clock; all state changes on posedge clk.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 game_active  in  1  level; high while a song is playing.
REQ-004 hit_valid  in  4  per-lane one-cycle judgment strobe, lane i = bit i.
REQ-005 hit_grade  in  8  lane i grade on bits [2i+1:2i]: 00 MISS, 01 GOOD, 10 GREAT, 11 PERFECT.
REQ-006 inp  out  2  grade forwarded to the score datapath; 00 when no judgment is issued.
REQ-007 combo  out  8  current combo count, registered together with inp.
REQ-008 max_combo  out  8  highest combo reached in the current song.
REQ-009 pending  out  4  per-lane holding-slot occupied flags.
REQ-010 overflow  out  1  sticky flag: a judgment was lost.
REQ-011 song_done  out  1  one-cycle pulse on DRAIN->IDLE.

Function
REQ-012 FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN when game_active=1.
- RUN->DRAIN when game_active=0.
- DRAIN->IDLE when pending=0 and no grant occurs this cycle.
- DRAIN ignores game_active.
REQ-013 On the IDLE->RUN edge, combo, max_combo and overflow shall clear to 0.
REQ-014 Each lane shall have a one-entry holding slot (pending bit plus 2-bit grade).
- hit_valid is captured into the slot only in RUN.
- hit_valid is ignored in IDLE and DRAIN.
REQ-015 hit_valid on an occupied slot that is not granted in the same cycle:
- new grade discarded, old entry kept;
- overflow set to 1.
REQ-016 hit_valid on a slot granted in the same cycle:
- new grade captured;
- pending stays 1;
- no overflow.
REQ-017 Arbitration is round-robin, at most one grant per cycle among pending lanes.
- Priority order: last+1, last+2, last+3, last (mod 4).
- last = most recently granted lane; reset value 3, so lane 0 has first priority.
REQ-018 A grant clears the granted slot and updates last at the same edge.
REQ-019 On a grant edge, inp <= granted grade.
- With no grant, inp <= 00.
REQ-020 Latency: hit_valid sampled at edge k -> earliest inp at edge k+1.
REQ-021 Combo update on a grant edge:
- grade 00: combo <= 0;
- otherwise: combo <= combo+1, saturating at 255.
- With no grant, combo holds.
REQ-022 max_combo <= max(max_combo, new combo) at the same edge, so it never lags combo.
REQ-023 overflow stays 1 until reset or the next IDLE->RUN edge.
REQ-024 Outputs are registered only; there is no combinational path from inputs to outputs.

Reset
REQ-025 Asynchronous reset shall force the following, regardless of clk:
- state=IDLE, all slots empty, last=3;
- inp=00, combo=0, max_combo=0, pending=0000, overflow=0, song_done=0.
REQ-026 Reset asserted mid-song shall discard all pending judgments; no inp is issued for them after release.

Verification
REQ-027 Single hit:
- Stimulus: RUN; lane 2 hit_valid with grade 11 at edge 5.
- Response: inp=11 and combo=1 after edge 6; inp=00 after edge 7.
REQ-028 Round-robin:
- Stimulus: last=3; lanes 0-3 hit together, grades 01,10,11,01.
- Response: inp sequence 01,10,11,01 on four consecutive edges; combo 1,2,3,4; pending drains 1110,1100,1000,0000.
REQ-029 Miss and saturation:
- Stimulus: combo=254; grants of 01, 01, then 00.
- Response: combo 255, 255, 0; max_combo=255.
REQ-030 Overflow:
- Stimulus: lanes 0 and 1 both hit in cycle c; lane 1 hits again in cycle c+1 while still pending.
- Response: overflow=1; lane 1's first grade is issued; the second is lost.
REQ-031 Drain:
- Stimulus: game_active falls with pending=0101.
- Response: two grants issued, then song_done pulses for one cycle; a hit_valid during DRAIN is ignored.
REQ-032 Reset mid-song:
- Stimulus: reset asserted with pending=1111 and combo=9.
- Response: outputs return to their REQ-025 values immediately; no inp is issued after release.
